rifl_tx_arbiter: RTL and testbench
==================================

// Module: rifl_tx_arbiter
// PURPOSE
//  Shares the single RIFL TX payload slot between NUM_CH user streams.
//  - Round-robin arbitration; each packet is atomic (one grant from first beat to tlast).
//  - Each beat is tagged with its channel ID and a {valid,last} header.
//  - Sits directly upstream of tx_controller and drives rifl_tx_payload.
//  - A beat is consumed only while rifl_tx_ready is high.
// PARAMETERS
//  NUM_CH        4    number of user channels, 2..16
//  PAYLOAD_WIDTH 240  tx_controller payload width, excluding the 2-bit header
//  CH_ID_WIDTH   4    channel tag width; requires 2**CH_ID_WIDTH >= NUM_CH
//  DATA_WIDTH    PAYLOAD_WIDTH-CH_ID_WIDTH  per-channel user data width (derived)
// PORTS
//  clk             in   1                   clock
//  rst             in   1                   synchronous, active-high reset
//  s_tdata         in   NUM_CH*DATA_WIDTH   channel i data in slice [i*DATA_WIDTH +: DATA_WIDTH]
//  s_tvalid        in   NUM_CH              per-channel beat valid
//  s_tlast         in   NUM_CH              per-channel last beat of packet
//  s_tready        out  NUM_CH              per-channel beat accepted
//  ch_enable       in   NUM_CH              channel may win a new arbitration
//  rifl_tx_ready   in   1                   tx_controller consumes rifl_tx_payload this cycle
//  rifl_tx_payload out  PAYLOAD_WIDTH+2     {valid,last,ch_id,data}
//  grant_id        out  CH_ID_WIDTH         currently granted channel
//  busy            out  1                   grant held (state GRANT)
// BEHAVIOUR
//  Reset values:
//   - state=ARB, out_full=0, last_grant=NUM_CH-1 (so channel 0 wins first).
//   - s_tready=0, busy=0, grant_id=0, rifl_tx_payload=0.
//  FSM ARB:
//   - req = s_tvalid & ch_enable.
//   - If req!=0, pick the first set bit scanning last_grant+1 upward, modulo NUM_CH.
//   - Register the winner into grant_id and go to GRANT next cycle.
//   - No beat is accepted in ARB: one bubble cycle per packet.
//  FSM GRANT (g = grant_id):
//   - take = s_tvalid[g] & s_tready[g].
//   - s_tready[g] = ~out_full | rifl_tx_ready; all other s_tready bits are 0.
//   - On take with s_tlast[g]=1: last_grant<=g, state<=ARB.
//  Output register (single stage, 1-cycle latency from take to rifl_tx_payload):
//   - take: out_full<=1, reg<={1'b1,s_tlast[g],g,s_tdata slice}.
//   - else if rifl_tx_ready: out_full<=0.
//   - Simultaneous consume + take: reg is overwritten and out_full stays 1 (no bubble).
//   - rifl_tx_payload = out_full ? reg : 0. Header 2'b00 means no data; 2'b01 is never driven.
//   - Payload is held stable while out_full & ~rifl_tx_ready.
//  Boundary conditions:
//   - ch_enable deasserted mid-packet: no effect; the packet completes.
//   - s_tvalid[g] low in GRANT: grant is held indefinitely (no timeout).
//   - All requesters idle: stay in ARB, last_grant unchanged.
//   - rifl_tx_ready low for N cycles: at most one beat is buffered; s_tready[g]=0 once out_full.
//   - rst mid-packet: buffered beat is dropped; upstream must restart the packet.
//  Width rules:
//   - grant_id is zero-extended into the CH_ID_WIDTH tag.
//   - last_grant+1 wraps at NUM_CH (not at 2**CH_ID_WIDTH).
// TESTING
//  1. Ch0, ch2 each 1-beat packets at cycle 0, ready=1:
//     payloads ch0 then ch2; headers 2'b11; tags 0 then 2; 2 cycles apart (ARB bubble).
//  2. All 4 channels valid continuously with 3-beat packets:
//     grant order 0,1,2,3,0; each packet contiguous; tlast beat header 2'b11, others 2'b10.
//  3. Ch1 mid-packet, ready low 5 cycles:
//     payload held constant; s_tready[1]=0 after 1 buffered beat; no beat lost or duplicated.
//  4. ch_enable[1] dropped after beat 1 of a 4-beat ch1 packet:
//     all 4 beats sent; ch1 then skipped while disabled, ch2 wins next.
//  5. rst asserted while out_full=1 in GRANT:
//     next cycle payload=0, s_tready=0, busy=0; the first grant after rst goes to ch0.
//  6. Back-to-back beats with ready=1: one beat per cycle, no gaps within a packet.

Source files
------------

// File: rtl/rifl_tx_arbiter.sv
// Round-robin arbiter that multiplexes NUM_CH packet streams into the single
// RIFL TX payload slot, tagging each beat with its channel and a {valid,last} header.
module rifl_tx_arbiter #(
    parameter int NUM_CH        = 4,
    parameter int PAYLOAD_WIDTH = 240,
    parameter int CH_ID_WIDTH   = 4,
    localparam int DATA_WIDTH   = PAYLOAD_WIDTH - CH_ID_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CH-1:0]            s_tvalid,
    input  logic [NUM_CH-1:0]            s_tlast,
    output logic [NUM_CH-1:0]            s_tready,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         rifl_tx_ready,
    output logic [PAYLOAD_WIDTH+1:0]     rifl_tx_payload,
    output logic [CH_ID_WIDTH-1:0]       grant_id,
    output logic                         busy
);
    localparam int IDX_W = $clog2(NUM_CH);

    localparam logic [0:0] ARB   = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]               state;
    logic [IDX_W-1:0]         gnt;
    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         arb_win;
    logic                     arb_found;
    logic                     out_full;
    logic [PAYLOAD_WIDTH+1:0] out_reg;
    logic [NUM_CH-1:0]        req;
    logic                     slot_free;
    logic                     take;

    assign req = s_tvalid & ch_enable;

    // Rotating priority: scan from last_grant+1, wrapping at NUM_CH rather than 2**IDX_W.
    always_comb begin
        arb_win   = '0;
        arb_found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!arb_found && req[(int'(last_grant) + k) % NUM_CH]) begin
                arb_found = 1'b1;
                arb_win   = IDX_W'((int'(last_grant) + k) % NUM_CH);
            end
        end
    end

    // The slot can take a new beat if empty, or if the current one leaves this cycle.
    assign slot_free = ~out_full | rifl_tx_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ready
        assign s_tready[i] = (state == GRANT) && (gnt == IDX_W'(i)) && slot_free && !rst;
    end

    assign take = s_tvalid[gnt] & s_tready[gnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            gnt        <= '0;
            last_grant <= IDX_W'(NUM_CH - 1);
            out_full   <= 1'b0;
            out_reg    <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (arb_found) begin
                        gnt   <= arb_win;
                        state <= GRANT;
                    end
                end
                default: begin
                    if (take && s_tlast[gnt]) begin
                        last_grant <= gnt;
                        state      <= ARB;
                    end
                end
            endcase

            if (take) begin
                out_full <= 1'b1;
                out_reg  <= {1'b1, s_tlast[gnt], CH_ID_WIDTH'(gnt),
                             s_tdata[int'(gnt)*DATA_WIDTH +: DATA_WIDTH]};
            end else if (rifl_tx_ready) begin
                out_full <= 1'b0;
            end
        end
    end

    assign rifl_tx_payload = out_full ? out_reg : '0;
    assign grant_id        = CH_ID_WIDTH'(gnt);
    assign busy            = (state == GRANT);

endmodule

// File: tb/tb_rifl_tx_arbiter.sv
// Scoreboard bench for rifl_tx_arbiter: per-channel source queues feed the DUT,
// expected payloads are queued up front and a monitor checks every consumed beat.
module tb_rifl_tx_arbiter;
    localparam int NUM_CH = 4;
    localparam int PW     = 240;
    localparam int IW     = 4;
    localparam int DW     = PW - IW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_CH*DW-1:0] s_tdata;
    logic [NUM_CH-1:0]    s_tvalid;
    logic [NUM_CH-1:0]    s_tlast;
    logic [NUM_CH-1:0]    s_tready;
    logic [NUM_CH-1:0]    ch_enable = '1;
    logic                 rifl_tx_ready = 1'b1;
    logic [PW+1:0]        rifl_tx_payload;
    logic [IW-1:0]        grant_id;
    logic                 busy;

    typedef logic [DW:0] beat_t;
    beat_t         chq[NUM_CH][$];
    logic [PW+1:0] exp_q[$];
    int            tq[$];
    int            checks = 0;
    int            errors = 0;
    int            ncons  = 0;
    int            cyc    = 0;

    rifl_tx_arbiter #(.NUM_CH(NUM_CH), .PAYLOAD_WIDTH(PW), .CH_ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .ch_enable(ch_enable), .rifl_tx_ready(rifl_tx_ready),
        .rifl_tx_payload(rifl_tx_payload), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mk_data(int ch, int pkt, int beat);
        logic [11:0] t;
        t = {ch[3:0], pkt[3:0], beat[3:0]};
        return DW'(t);
    endfunction

    function automatic logic [PW+1:0] mk_pl(int ch, int pkt, int beat, logic last);
        return {1'b1, last, IW'(ch), mk_data(ch, pkt, beat)};
    endfunction

    task automatic chk_pl(string name, logic [PW+1:0] act, logic [PW+1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_int(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic load_pkt(int ch, int pkt, int nb, bit expect_it);
        for (int b = 0; b < nb; b++) begin
            chq[ch].push_back({(b == nb - 1), mk_data(ch, pkt, b)});
            if (expect_it) exp_q.push_back(mk_pl(ch, pkt, b, (b == nb - 1)));
        end
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < NUM_CH; i++)
            if (chq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_src();
        beat_t b;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chq[i].size() > 0) begin
                b = chq[i][0];
                s_tvalid[i]           = 1'b1;
                s_tlast[i]            = b[DW];
                s_tdata[i*DW +: DW]   = b[DW-1:0];
            end else begin
                s_tvalid[i]           = 1'b0;
                s_tlast[i]            = 1'b0;
                s_tdata[i*DW +: DW]   = '0;
            end
        end
    endtask

    // Source model: sample handshakes mid-cycle, retire accepted beats after the edge.
    initial begin : driver
        logic [NUM_CH-1:0] acc;
        drive_src();
        forever begin
            @(negedge clk);
            acc = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_CH; i++)
                if (acc[i] && chq[i].size() > 0) void'(chq[i].pop_front());
            drive_src();
        end
    end

    initial begin : monitor
        logic [PW+1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk_int("hdr_not_01", int'(rifl_tx_payload[PW+1:PW] == 2'b01), 0);
                if (rifl_tx_ready && rifl_tx_payload[PW+1]) begin
                    ncons++;
                    tq.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk_pl("unexpected_beat", rifl_tx_payload, '0);
                    end else begin
                        e = exp_q.pop_front();
                        chk_pl("beat", rifl_tx_payload, e);
                    end
                end
            end
        end
    end

    task automatic wait_drain(string name, bit need_src_empty);
        int n = 0;
        while (!(exp_q.size() == 0 && (!need_src_empty || src_empty()) && !busy &&
                 !rifl_tx_payload[PW+1]) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) chk_int({name, "_timeout"}, n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cons(string name, int target);
        int n = 0;
        while (ncons < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 1000) chk_int({name, "_timeout"}, ncons, target);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int base;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_pl("rst_payload", rifl_tx_payload, '0);
        chk_int("rst_tready", int'(s_tready), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_grant", int'(grant_id), 0);

        // 1: single-beat packets on ch0 and ch2, one ARB bubble between them
        load_pkt(0, 1, 1, 1'b1);
        load_pkt(2, 1, 1, 1'b1);
        base = tq.size();
        wait_drain("t1", 1'b1);
        chk_int("t1_gap", tq[base+1] - tq[base], 2);

        // 2/6: all channels, 3-beat packets, back-to-back with ready high
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        load_pkt(0, 2, 3, 1'b1);
        load_pkt(1, 2, 3, 1'b1);
        load_pkt(2, 2, 3, 1'b1);
        load_pkt(3, 2, 3, 1'b1);
        load_pkt(0, 3, 3, 1'b1);
        base = tq.size();
        wait_drain("t2", 1'b1);
        for (int k = 1; k < 15; k++)
            chk_int("t2_gap", tq[base+k] - tq[base+k-1], (k % 3 == 0) ? 2 : 1);

        // 3: backpressure mid-packet on ch1
        @(negedge clk);
        load_pkt(1, 4, 4, 1'b1);
        wait_cons("t3", ncons + 1);
        rifl_tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk_pl("t3_hold", rifl_tx_payload, mk_pl(1, 4, 1, 1'b0));
            chk_int("t3_tready1", int'(s_tready[1]), 0);
        end
        @(posedge clk);
        #1 rifl_tx_ready = 1'b1;
        wait_drain("t3", 1'b1);

        // 4: ch1 disabled mid-packet finishes, then is skipped until re-enabled
        @(negedge clk);
        load_pkt(1, 5, 4, 1'b1);
        load_pkt(1, 6, 1, 1'b0);
        wait_cons("t4", ncons + 1);
        ch_enable[1] = 1'b0;
        @(negedge clk);
        load_pkt(2, 5, 1, 1'b1);
        load_pkt(0, 5, 1, 1'b1);
        wait_drain("t4a", 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk_int("t4_skip_busy", int'(busy), 0);
        end
        chk_int("t4_pending", chq[1].size(), 1);
        @(posedge clk);
        #1;
        exp_q.push_back(mk_pl(1, 6, 0, 1'b1));
        ch_enable[1] = 1'b1;
        wait_drain("t4b", 1'b1);

        // 5: reset while a beat is buffered
        rifl_tx_ready = 1'b0;
        @(negedge clk);
        load_pkt(3, 7, 4, 1'b0);
        n = 0;
        while (!rifl_tx_payload[PW+1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_int("t5_buffered", int'(rifl_tx_payload[PW+1]), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        chq[3].delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_pl("t5_payload", rifl_tx_payload, '0);
        chk_int("t5_tready", int'(s_tready), 0);
        chk_int("t5_busy", int'(busy), 0);
        @(posedge clk);
        #1 rifl_tx_ready = 1'b1;
        @(negedge clk);
        load_pkt(0, 8, 1, 1'b1);
        load_pkt(3, 8, 1, 1'b1);
        n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_int("t5_first_grant", int'(grant_id), 0);
        wait_drain("t5", 1'b1);

        chk_int("final_exp_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
